uart_byte_tx: RTL
=================

# uart_byte_tx

Byte-level UART serializer directly downstream of the UART driver. The driver pops its FIFO one byte at a time into this block over a valid/ready handshake, and the block shifts each byte onto `UART_TX` as an 8N1 frame (optionally 8E1) at a fixed baud rate. `tx_ready` is the backpressure that gates the driver's FIFO reads.

## Interface
- `CLKS_PER_BIT`, default 868: `sys_clock` cycles per bit period; legal range 2..65535.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `sys_clock`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `tx_data`  in  8  byte to send; sampled only on an accept cycle.
- `tx_valid`  in  1  driver has a byte on `tx_data`.
- `tx_ready`  out  1  block can accept a byte this cycle.
- `tx_busy`  out  1  a frame is in progress.
- `UART_TX`  out  1  serial line, idle high, registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `tx_ready`=1, `UART_TX`=1, `tx_busy`=0.
  - Accept occurs when `tx_valid` && `tx_ready`. On accept, latch `tx_data` into the shift register and go to START.
- START: `UART_TX`=0 for one bit period, then go to DATA.
- DATA:
  - Send 8 bits LSB first; the shift register shifts right once per bit period.
  - A 3-bit index counts 0..7. After bit 7, go to PARITY if the macro is enabled, otherwise STOP.
- PARITY: `UART_TX` = XOR of the 8 latched bits (even parity) for one bit period, then go to STOP.
- STOP: `UART_TX`=1 for `STOP_BITS` bit periods, then go to IDLE.
- Bit timing: a 16-bit down-counter loads `CLKS_PER_BIT-1` on every state/bit entry. The bit ends in the cycle the counter reads 0.
- `tx_ready`=0 and `tx_busy`=1 in every state except IDLE. A `tx_valid` held during a frame is ignored, and `tx_data` may change freely.
- Reset values: `UART_TX`=1, `tx_ready`=1, `tx_busy`=0, state IDLE, counters 0.
- Reset mid-frame: the line returns high asynchronously, the in-flight byte is dropped, and there is no partial-frame recovery.

## Timing
- Accept at edge N. START begins at edge N+1, so `UART_TX` falls 1 cycle after accept.
- Each bit is exactly `CLKS_PER_BIT` cycles. Bit k of the data byte starts at N+1+(k+1)·`CLKS_PER_BIT`.
- Frame length is (10 + P + `STOP_BITS`−1)·`CLKS_PER_BIT` cycles, where P=1 with the macro and 0 without.
- `tx_ready` rises on the cycle after the last stop bit ends. Back-to-back throughput is therefore one frame plus 1 idle cycle per byte.
- `tx_valid` may rise in the same cycle `tx_ready` rises; the accept then happens in that cycle.
- Simultaneous `tx_valid` and reset release: the first accept is at the first edge after `reset_n` goes high.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and frames are 8E1 (or 8E2 with `STOP_BITS`=2).
- `UART_TX_PARITY_EN` undefined: the PARITY state and parity logic are not compiled. Frames are 8N1/8N2, and DATA transitions directly to STOP.

## Structure
- Package `uart_pkg`:
  - state enum `uart_tx_state_t`
  - `UART_DATA_BITS`=8
  - `UART_IDLE_LEVEL`=1'b1
  - the default `CLKS_PER_BIT` constant, shared with the driver
- Sub-module `uart_bit_timer`:
  - contains the 16-bit down-counter
  - inputs: `restart`
  - outputs: `bit_done`
  - parameter: `CLKS_PER_BIT`

## Test plan
- `CLKS_PER_BIT`=4, parity off, send 0x55 -> `UART_TX` reads 0,1,0,1,0,1,0,1,0,1 (start bit, LSB-first data, stop), each level held 4 cycles; `tx_ready` returns 41 cycles after accept.
- Parity on, send 0x07 -> the parity bit is 1 in the 10th bit slot, the stop bit follows, and the frame is 44 cycles.
- `tx_valid` held high with bytes 0xA0, 0xA1, 0xA2 -> three frames; each frame's start bit begins exactly 1 idle cycle plus 1 cycle after the previous stop bit ends; decoded data is correct.
- `tx_data` toggles to 0xFF mid-frame while a 0x00 frame is sending -> the transmitted data stays 0x00, and no extra accept occurs.
- `reset_n` pulsed low during bit 3 of 0x3C -> `UART_TX`=1 within the reset cycle, `tx_ready`=1 after release, and the next byte 0x81 is sent cleanly.
- `STOP_BITS`=2, `CLKS_PER_BIT`=2, send 0xF0 -> the line stays high for 4 cycles after the data bits, before `tx_ready` rises.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter state encoding.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam logic        UART_IDLE_LEVEL           = 1'b1;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned UART_TIMER_W              = 16;
  localparam int unsigned UART_IDX_W                = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: reloads CLKS_PER_BIT-1 on restart, bit_done while it reads 0.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic sys_clock,
  input  logic reset_n,
  input  logic restart,
  output logic bit_done
);

  localparam logic [UART_TIMER_W-1:0] RELOAD = UART_TIMER_W'(CLKS_PER_BIT - 1);

  logic [UART_TIMER_W-1:0] cnt;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - UART_TIMER_W'(1);
    end
  end

  assign bit_done = (cnt == '0);

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-level UART serializer, 8N1/8N2 by default; 8E1/8E2 when UART_TX_PARITY_EN is defined.
// Line, ready and busy are registered and lag the FSM state by one cycle.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       sys_clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       UART_TX
);

  uart_tx_state_t            state, state_d;
  logic [UART_DATA_BITS-1:0] shreg, shreg_d;
  logic [UART_IDX_W-1:0]     bit_idx, bit_idx_d;
  logic                      stop_idx, stop_idx_d;
  logic                      tx_ready_d, tx_busy_d, uart_tx_d;
  logic                      restart, bit_done, accept_c;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .restart   (restart),
    .bit_done  (bit_done)
  );

  // Registers: FSM state, datapath and registered outputs.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      UART_TX  <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      tx_ready <= tx_ready_d;
      tx_busy  <= tx_busy_d;
      UART_TX  <= uart_tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next state, datapath updates and line level for the current state.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    restart    = 1'b0;
    accept_c   = 1'b0;
    uart_tx_d  = UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state)
      ST_IDLE: begin
        accept_c = tx_valid && tx_ready;
        if (accept_c) begin
          shreg_d = tx_data;
          restart = 1'b1;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      ST_START: begin
        uart_tx_d = 1'b0;
        if (bit_done) begin
          restart   = 1'b1;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        uart_tx_d = shreg[0];
        if (bit_done) begin
          restart   = 1'b1;
          shreg_d   = {1'b0, shreg[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx + UART_IDX_W'(1);
          if (bit_idx == UART_IDX_W'(UART_DATA_BITS - 1)) begin
            stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        uart_tx_d = parity_q;
        if (bit_done) begin
          restart    = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        uart_tx_d = 1'b1;
        if (bit_done) begin
          restart = 1'b1;
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready drops on the accept edge and returns one cycle after re-entering IDLE.
    tx_ready_d = (state == ST_IDLE) && (state_d == ST_IDLE);
    tx_busy_d  = !tx_ready_d;
  end

endmodule
